// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, blank pattern and the active-low hex segment table.
package seg7_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot timer: counts clk cycles within one digit slot and flags the last
// blank cycle and the last cycle of the slot.
module scan_tick_gen #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end,
    output logic slot_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign blank_end = (cnt == CW'(BLANK_CYC - 1));
    assign slot_end  = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display scanner with anti-ghost blanking,
// frame-synchronous value update and optional leading-zero suppression.
//
//   state   | meaning
//   S_BLANK | all anodes off, segments dark; start of every digit slot
//   S_SHOW  | one anode on, segments from the display register
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        frame_start
);

    state_t      state;
    logic [2:0]  digit;
    logic [31:0] disp;
    logic [7:0]  disp_dp;
    logic [31:0] shadow;
    logic [7:0]  shadow_dp;
    logic        pending;

    logic        blank_end;
    logic        slot_end;
    logic        wrap;

    logic [3:0]  nib;
    logic        upper_zero;
    logic        suppress;
    logic [6:0]  show_seg;
    logic [7:0]  show_an;
    logic        show_dp;

    scan_tick_gen #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign wrap = (state == S_SHOW) && slot_end && (digit == 3'(DIGITS - 1));

    // A digit is a leading zero when it and every higher active nibble are zero
    always_comb begin
        nib        = disp[{digit, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((j >= int'(digit)) && (j < DIGITS) && (disp[j*4 +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        suppress = lz_en && (digit != 3'd0) && upper_zero;
        show_seg = suppress ? SEG_BLANK : hex_seg(nib);
        show_an  = ~(8'h01 << digit);
        show_dp  = ~disp_dp[digit];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BLANK;
            digit       <= '0;
            disp        <= '0;
            disp_dp     <= '0;
            shadow      <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end

            // The display register only moves at the frame boundary
            if (wrap) begin
                if (load) begin
                    disp    <= value;
                    disp_dp <= dp_in;
                end else if (pending) begin
                    disp    <= shadow;
                    disp_dp <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            case (state)
                S_BLANK: begin
                    if (blank_end) begin
                        state <= S_SHOW;
                        seg_n <= show_seg;
                        dp_n  <= show_dp;
                        an_n  <= show_an;
                    end
                end
                S_SHOW: begin
                    if (slot_end) begin
                        state       <= S_BLANK;
                        digit       <= wrap ? 3'd0 : digit + 3'd1;
                        seg_n       <= SEG_BLANK;
                        dp_n        <= 1'b1;
                        an_n        <= 8'hFF;
                        frame_start <= wrap;
                    end else begin
                        seg_n <= show_seg;
                        dp_n  <= show_dp;
                        an_n  <= show_an;
                    end
                end
                default: begin
                    state <= S_BLANK;
                end
            endcase
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000, clk cycles per digit slot; legal when CLK_DIV > BLANK_CYC.
REQ-003 Parameter BLANK_CYC, default 16, anti-ghost blank cycles at the start of each slot; legal when BLANK_CYC >= 1.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 load  in  1  one-cycle strobe that captures value and dp_in.
REQ-007 value  in  32  eight hex nibbles; nibble i drives digit i (digit 0 is the LSB nibble).
REQ-008 dp_in  in  8  per-digit decimal point request, active-high.
REQ-009 lz_en  in  1  leading-zero suppression enable, level input, sampled every cycle.
REQ-010 seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp_n  out  1  decimal point, active-low.
REQ-012 an_n  out  8  digit enables, active-low; bits >= DIGITS held at 1.
REQ-013 frame_start  out  1  one-cycle pulse on entry to the digit-0 slot.

Function
REQ-014 FSM states are S_BLANK and S_SHOW; a slot is BLANK_CYC cycles in S_BLANK followed by CLK_DIV-BLANK_CYC cycles in S_SHOW.
REQ-015 S_BLANK shall drive an_n all 1, seg_n 7'h7F and dp_n 1.
REQ-016 S_SHOW shall drive only an_n[digit] to 0, seg_n from the decoded nibble and dp_n = ~dp[digit].
REQ-017 On leaving S_SHOW, digit shall increment, wrapping from DIGITS-1 to 0; a full frame is DIGITS*CLK_DIV cycles.
REQ-018 All outputs shall be registered; an_n, seg_n and dp_n shall change in the same cycle.
REQ-019 Decode shall be active-low hex, for example: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-020 load shall write a shadow register (value, dp_in) and set pending; a later load before the next wrap overwrites it, so the latest value wins.
REQ-021 At the wrap cycle (digit DIGITS-1 to 0), the display register shall take value/dp_in if load=1 that cycle, else the shadow if pending=1; pending then clears.
REQ-022 The display register shall never change mid-frame, so a frame is never torn.
REQ-023 With lz_en=1, digit i>0 shall be blanked (seg_n 7'h7F, an_n still asserted) when nibbles i..DIGITS-1 of the display register are all zero, and dp_n shall still follow dp[i].
REQ-024 Digit 0 shall never be suppressed.
REQ-025 frame_start shall pulse in the first S_BLANK cycle of digit 0 after each wrap; no pulse on reset exit.

Reset
REQ-026 With rst_n=0: state S_BLANK, digit 0, slot counter 0, display/shadow/pending 0, seg_n 7'h7F, dp_n 1, an_n 8'hFF, frame_start 0.
REQ-027 Reset asserted mid-frame shall force the REQ-026 values immediately, without waiting for a clock.
REQ-028 A load lost to reset is discarded.
REQ-029 After release, the first slot shall start with a full BLANK_CYC blank.

Structure
REQ-030 A shared package seg7_pkg shall hold the state enum, the segment constants (SEG_BLANK=7'h7F) and the 16-entry hex pattern table.
REQ-031 One sub-module scan_tick_gen shall hold the slot counter and emit blank_end and slot_end strobes.
REQ-032 The FSM, register set and decode shall live in seg7_scan_ctrl.
REQ-033 Expected size: 150-300 lines of RTL.

Verification (DIGITS=4, CLK_DIV=8, BLANK_CYC=2 unless stated)
REQ-034 Reset release, no load -> an_n cycles 1110,1101,1011,0111 (each low 6 of 8 cycles), seg_n=1000000 while shown, frame_start every 32 cycles.
REQ-035 load value=32'h0000_A81F mid-frame -> old digits persist to the wrap; next frame shows seg_n 0001110,1111001,0000000,0001000 for digits 0..3.
REQ-036 Two loads in one frame (32'h1111, then 32'h2222) -> only 2222 displayed at the next wrap; load coinciding with the wrap cycle -> displayed in the immediately following frame.
REQ-037 lz_en=1, value=32'h0000_0050 -> digits 3 and 2 blank with an_n asserted, digit 1 shows 5, digit 0 shows 0; value 0 -> only digit 0 shows 0.
REQ-038 dp_in=4'b0100 -> dp_n low only during digit 2 S_SHOW, high in all S_BLANK cycles.
REQ-039 rst_n pulsed low mid-S_SHOW of digit 2 -> outputs take the reset values asynchronously; after release digit 0 blanks for 2 cycles, display register 0.
